// File: rtl/mem_sys_pkg.sv
// rtl/mem_sys_pkg.sv - shared FSM encodings and width defaults for the memory access initiator
package mem_sys_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int DEFAULT_LEN_WIDTH  = 4;
    localparam int MAX_READ_LATENCY   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_initiator_if.sv
// rtl/mem_access_initiator_if.sv - request/response and memory-side signal bundle
interface mem_access_initiator_if
    import mem_sys_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
);
    logic                  Req_Valid_i;
    logic                  Req_Ready_o;
    logic                  Req_Write_i;
    logic [ADDR_WIDTH-1:0] Req_Addr_i;
    logic [DATA_WIDTH-1:0] Req_Data_i;
    logic [LEN_WIDTH-1:0]  Req_Len_i;
    logic                  Rsp_Valid_o;
    logic [DATA_WIDTH-1:0] Rsp_Data_o;
    logic                  Rsp_Last_o;
    logic                  Busy_o;
    logic                  Mem_Write_Enable_o;
    logic [ADDR_WIDTH-1:0] Mem_Address_o;
    logic [DATA_WIDTH-1:0] Mem_Write_Data_o;
    logic [DATA_WIDTH-1:0] Mem_Read_Data_i;

    modport master (
        input  Req_Valid_i, Req_Write_i, Req_Addr_i, Req_Data_i, Req_Len_i, Mem_Read_Data_i,
        output Req_Ready_o, Rsp_Valid_o, Rsp_Data_o, Rsp_Last_o, Busy_o,
               Mem_Write_Enable_o, Mem_Address_o, Mem_Write_Data_o
    );

    modport slave (
        output Req_Valid_i, Req_Write_i, Req_Addr_i, Req_Data_i, Req_Len_i, Mem_Read_Data_i,
        input  Req_Ready_o, Rsp_Valid_o, Rsp_Data_o, Rsp_Last_o, Busy_o,
               Mem_Write_Enable_o, Mem_Address_o, Mem_Write_Data_o
    );

endinterface

// File: rtl/mem_rd_tag_pipe.sv
// rtl/mem_rd_tag_pipe.sv - DEPTH-stage {valid,last} delay line that tracks reads in flight
module mem_rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_last,
    output logic o_valid,
    output logic o_last,
    output logic o_busy
);
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_last  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_last[0]  <= i_last;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_last  = r_last[DEPTH-1];
    assign o_busy  = |{r_valid, r_last};

endmodule

// File: rtl/mem_access_initiator.sv
// rtl/mem_access_initiator.sv - single-word write / burst-read requester for the memory system
// Issues one address per cycle for bursts; the tag pipe marks which returning words are valid/last.
module mem_access_initiator
    import mem_sys_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH    = DEFAULT_LEN_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_access_initiator_if.master bus
);
    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_tag_valid;
    logic                  w_tag_last;
    logic                  w_tag_busy;

    // Decoded purely from registers so there is no path from Req_Valid_i.
    assign bus.Req_Ready_o = (r_state == IDLE) && !w_tag_busy;
    assign w_accept        = bus.Req_Valid_i && bus.Req_Ready_o;
    assign w_issue         = (r_state == RD_ISSUE);
    assign w_issue_last    = w_issue && (r_cnt == r_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.Req_Write_i) begin
                        w_next_state = WRITE;
                    end else begin
                        w_next_state = RD_ISSUE;
                    end
                end
            end
            WRITE:    w_next_state = IDLE;
            RD_ISSUE: if (r_cnt == r_len) w_next_state = RD_DRAIN;
            RD_DRAIN: if (w_tag_valid && w_tag_last) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_addr <= bus.Req_Addr_i;
            r_cnt  <= '0;
            if (bus.Req_Write_i) begin
                r_wdata <= bus.Req_Data_i;
            end else begin
                r_len <= bus.Req_Len_i;
            end
        end else if (w_issue && !w_issue_last) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_cnt  <= r_cnt + LEN_WIDTH'(1);
        end
    end

    // Read words pass straight through on beats; the register only keeps the last one visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_data <= '0;
        end else if (w_tag_valid) begin
            r_rsp_data <= bus.Mem_Read_Data_i;
        end
    end

    mem_rd_tag_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_issue),
        .i_last  (w_issue_last),
        .o_valid (w_tag_valid),
        .o_last  (w_tag_last),
        .o_busy  (w_tag_busy)
    );

    assign bus.Rsp_Valid_o        = w_tag_valid;
    assign bus.Rsp_Last_o         = w_tag_valid && w_tag_last;
    assign bus.Rsp_Data_o         = w_tag_valid ? bus.Mem_Read_Data_i : r_rsp_data;
    assign bus.Busy_o             = (r_state != IDLE) || w_tag_busy;
    assign bus.Mem_Write_Enable_o = (r_state == WRITE);
    assign bus.Mem_Address_o      = r_addr;
    assign bus.Mem_Write_Data_o   = r_wdata;

endmodule
